// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: debounced button levels and the counter-chain
// status come in; enable, count tick, clear pulse and FSM state go out.
// All signals are plain levels or single-cycle pulses, so there is no
// valid/ready handshake.
interface stopwatch_ctrl_if;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_clear;
    logic       at_max;
    logic       enable;
    logic       tick;
    logic       clear;
    logic [1:0] state;

    // Button/counter side that drives the controller.
    modport master (
        output btn_start, btn_stop, btn_clear, at_max,
        input  enable, tick, clear, state
    );

    // The controller itself.
    modport slave (
        input  btn_start, btn_stop, btn_clear, at_max,
        output enable, tick, clear, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for the stopwatch seconds/minutes counter chain.
// Button levels become single-cycle events, a 3-state (plus DONE) FSM gates
// a CLK_DIV prescaler that emits the 1 Hz count tick, and a clear event
// produces a one-cycle registered clear pulse to both counters.
module stopwatch_ctrl #(
    parameter int CLK_DIV     = 50_000_000,
    parameter bit STOP_AT_MAX = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  sw
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        DONE    = 2'b11
    } state_t;

    localparam int               CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DIV_ONE = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] div_cnt;
    logic             clear_q;
    logic             btn_start_q;
    logic             btn_stop_q;
    logic             btn_clear_q;

    logic ev_start;
    logic ev_stop;
    logic ev_clear;
    logic terminal;
    logic max_hit;

    // Rising-edge events: a held button yields exactly one event.
    assign ev_start = sw.btn_start & ~btn_start_q;
    assign ev_stop  = sw.btn_stop  & ~btn_stop_q;
    assign ev_clear = sw.btn_clear & ~btn_clear_q;

    // Last prescaler cycle of the current second, and the freeze condition.
    assign terminal = (div_cnt == DIV_MAX);
    assign max_hit  = STOP_AT_MAX & sw.at_max;

    // Button history registers feeding the edge detectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_start_q <= 1'b0;
            btn_stop_q  <= 1'b0;
            btn_clear_q <= 1'b0;
        end else begin
            btn_start_q <= sw.btn_start;
            btn_stop_q  <= sw.btn_stop;
            btn_clear_q <= sw.btn_clear;
        end
    end

    // FSM, prescaler and clear pulse. Clear beats stop beats start, but an
    // event that is ignored in the current state never hides a lower one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_cnt <= '0;
            clear_q <= 1'b0;
        end else begin
            clear_q <= ev_clear;
            if (ev_clear) begin
                state_q <= IDLE;
                div_cnt <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ev_start) begin
                            state_q <= RUNNING;
                            div_cnt <= '0;
                        end
                    end
                    RUNNING: begin
                        if (ev_stop) begin
                            // Partial second is kept; a stop on the terminal
                            // cycle still lets that cycle's tick out.
                            state_q <= PAUSED;
                        end else if (terminal && max_hit) begin
                            state_q <= DONE;
                            div_cnt <= '0;
                        end else if (terminal) begin
                            div_cnt <= '0;
                        end else begin
                            div_cnt <= div_cnt + DIV_ONE;
                        end
                    end
                    PAUSED: begin
                        if (ev_start) begin
                            state_q <= RUNNING;
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q <= IDLE;
                        div_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Output decode of registered state; no extra latency.
    assign sw.enable = (state_q == RUNNING);
    assign sw.tick   = (state_q == RUNNING) && terminal && !max_hit;
    assign sw.clear  = clear_q;
    assign sw.state  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with CLK_DIV=4. Two instances share the same
// stimulus: dut1 freezes at 99:59, dut0 lets the counters wrap.
// Observed vector per cycle is {state, enable, tick, clear}.
module tb_stopwatch_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_PAUS = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    logic [4:0] exp0_q[$];

    stopwatch_ctrl_if sw1 ();
    stopwatch_ctrl_if sw0 ();

    assign sw0.btn_start = sw1.btn_start;
    assign sw0.btn_stop  = sw1.btn_stop;
    assign sw0.btn_clear = sw1.btn_clear;
    assign sw0.at_max    = sw1.at_max;

    stopwatch_ctrl #(.CLK_DIV(4), .STOP_AT_MAX(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .sw  (sw1.slave)
    );

    stopwatch_ctrl #(.CLK_DIV(4), .STOP_AT_MAX(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .sw  (sw0.slave)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst           = 1'b1;
        sw1.btn_start = 1'b0;
        sw1.btn_stop  = 1'b0;
        sw1.btn_clear = 1'b0;
        sw1.at_max    = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // Driver: apply one cycle of inputs just after the rising edge.
    task automatic drive(input logic st, input logic sp, input logic cl,
                         input logic am, input logic r);
        @(posedge clk);
        #1;
        sw1.btn_start = st;
        sw1.btn_stop  = sp;
        sw1.btn_clear = cl;
        sw1.at_max    = am;
        rst           = r;
    endtask

    // Brings both instances back to IDLE with all buttons low.
    task automatic go_idle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        logic [4:0] obs;
        logic [2:0] b;
        for (int i = 0; i < 7; i++) begin
            b = (i < 4) ? 3'(i + 1) : 3'b000;
            drive(b[0], b[1], b[2], 1'b0, (i < 6));
            exp_q.push_back({S_IDLE, 3'b000});
            @(negedge clk);
            obs = {sw1.state, sw1.enable, sw1.tick, sw1.clear};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset cyc %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_run_tick();
        logic [4:0] exp;
        logic [4:0] obs;
        for (int i = 0; i <= 13; i++) begin
            drive((i < 6), 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 0) exp_q.push_back({S_IDLE, 3'b000});
            else        exp_q.push_back({S_RUN, 1'b1, (i % 4 == 0), 1'b0});
            @(negedge clk);
            obs = {sw1.state, sw1.enable, sw1.tick, sw1.clear};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL run_tick cyc %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_pause();
        logic [4:0] exp;
        logic [4:0] obs;
        for (int i = 0; i <= 20; i++) begin
            drive((i == 0 || i == 14), (i == 3), 1'b0, 1'b0, 1'b0);
            if (i == 0)                 exp_q.push_back({S_IDLE, 3'b000});
            else if (i <= 3)            exp_q.push_back({S_RUN, 3'b100});
            else if (i <= 14)           exp_q.push_back({S_PAUS, 3'b000});
            else                        exp_q.push_back({S_RUN, 1'b1, (i == 16 || i == 20), 1'b0});
            @(negedge clk);
            obs = {sw1.state, sw1.enable, sw1.tick, sw1.clear};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL pause cyc %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_clear_hold();
        logic [4:0] exp;
        logic [4:0] obs;
        for (int i = 0; i <= 16; i++) begin
            drive((i == 0 || i == 12), 1'b0, (i >= 6 && i <= 10), 1'b0, 1'b0);
            if (i == 0)       exp_q.push_back({S_IDLE, 3'b000});
            else if (i <= 6)  exp_q.push_back({S_RUN, 1'b1, (i == 4), 1'b0});
            else if (i == 7)  exp_q.push_back({S_IDLE, 3'b001});
            else if (i <= 12) exp_q.push_back({S_IDLE, 3'b000});
            else              exp_q.push_back({S_RUN, 1'b1, (i == 16), 1'b0});
            @(negedge clk);
            obs = {sw1.state, sw1.enable, sw1.tick, sw1.clear};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL clear_hold cyc %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_stop_at_max();
        logic [4:0] exp;
        logic [4:0] obs;
        for (int i = 0; i <= 9; i++) begin
            drive((i == 0 || i == 5), 1'b0, (i == 7), (i == 3 || i == 4), 1'b0);
            if (i == 0) begin
                exp_q.push_back({S_IDLE, 3'b000});
                exp0_q.push_back({S_IDLE, 3'b000});
            end else if (i <= 4) begin
                exp_q.push_back({S_RUN, 3'b100});
                exp0_q.push_back({S_RUN, 1'b1, (i == 4), 1'b0});
            end else if (i <= 7) begin
                exp_q.push_back({S_DONE, 3'b000});
                exp0_q.push_back({S_RUN, 3'b100});
            end else if (i == 8) begin
                exp_q.push_back({S_IDLE, 3'b001});
                exp0_q.push_back({S_IDLE, 3'b001});
            end else begin
                exp_q.push_back({S_IDLE, 3'b000});
                exp0_q.push_back({S_IDLE, 3'b000});
            end
            @(negedge clk);
            obs = {sw1.state, sw1.enable, sw1.tick, sw1.clear};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stop_at_max1 cyc %0d: got %b expected %b", i, obs, exp);
            end
            obs = {sw0.state, sw0.enable, sw0.tick, sw0.clear};
            exp = exp0_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stop_at_max0 cyc %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        logic [4:0] obs;
        logic st;
        logic sp;
        for (int i = 0; i <= 13; i++) begin
            st = (i == 0 || i == 3 || i == 5 || i == 7 || i == 10);
            sp = (i == 3 || i == 7 || i == 10);
            drive(st, sp, (i == 3), 1'b0, 1'b0);
            if (i == 0 || i == 5)      exp_q.push_back({S_IDLE, 3'b000});
            else if (i <= 3)           exp_q.push_back({S_RUN, 3'b100});
            else if (i == 4)           exp_q.push_back({S_IDLE, 3'b001});
            else if (i <= 7)           exp_q.push_back({S_RUN, 3'b100});
            else if (i <= 10)          exp_q.push_back({S_PAUS, 3'b000});
            else                       exp_q.push_back({S_RUN, 1'b1, (i == 13), 1'b0});
            @(negedge clk);
            obs = {sw1.state, sw1.enable, sw1.tick, sw1.clear};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_priority();
        logic [4:0] exp;
        logic [4:0] obs;
        for (int i = 0; i <= 10; i++) begin
            drive((i == 0 || i == 6), 1'b0, (i == 3), 1'b0, (i == 3 || i == 4));
            if (i == 0)      exp_q.push_back({S_IDLE, 3'b000});
            else if (i <= 3) exp_q.push_back({S_RUN, 3'b100});
            else if (i <= 6) exp_q.push_back({S_IDLE, 3'b000});
            else             exp_q.push_back({S_RUN, 1'b1, (i == 10), 1'b0});
            @(negedge clk);
            obs = {sw1.state, sw1.enable, sw1.tick, sw1.clear};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_priority cyc %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_run_tick();
        go_idle();
        test_pause();
        go_idle();
        test_clear_hold();
        go_idle();
        test_stop_at_max();
        test_back_to_back();
        go_idle();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
